// File: rtl/text_pkg.sv
// text_pkg
// Shared constants and types for the character-RAM arbiter.
//   COLS/ROWS/CELLS : text-mode geometry (80 x 60 = 4800 cells)
//   ADDR_W          : character RAM address width
//   CLEAR_CHAR      : code written into every cell by the clear engine
//   clr_state_t     : clear-engine FSM state
//   cell_addr()     : row/column to linear cell address
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 13;

  localparam logic [7:0]        CLEAR_CHAR = 8'h20;
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] NUM_CELLS  = ADDR_W'(CELLS);

  typedef enum logic {
    CLR_IDLE   = 1'b0,
    CLR_ACTIVE = 1'b1
  } clr_state_t;

  // Linear cell address row*COLS + col; the largest result (4799) fits ADDR_W.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                  input logic [6:0] col);
    cell_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/text_clear_engine.sv
// text_clear_engine
// Clear-screen sequencer: walks every cell once, requesting one RAM write per
// cell from the arbiter.
//   i_clk, i_reset : pixel clock, synchronous active-high reset
//   i_start        : start pulse (ignored while a clear is running)
//   i_grant        : arbiter grants the current write this cycle
//   o_req          : a write to o_addr is pending
//   o_addr         : cell to be written with CLEAR_CHAR
//   o_busy         : clear in progress
//   o_done         : one-cycle pulse after the last cell was granted
import text_pkg::*;

module text_clear_engine (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_grant,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy,
  output logic              o_done
);

  clr_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;

  // Clear FSM, cell counter and registered busy/done flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= CLR_IDLE;
      r_addr  <= {ADDR_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CLR_IDLE: begin
          if (i_start) begin
            r_state <= CLR_ACTIVE;
            r_addr  <= {ADDR_W{1'b0}};
            r_busy  <= 1'b1;
          end
        end
        CLR_ACTIVE: begin
          if (i_grant) begin
            if (r_addr == LAST_CELL) begin
              r_state <= CLR_IDLE;
              r_addr  <= {ADDR_W{1'b0}};
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_addr <= r_addr + 13'd1;
            end
          end
        end
        default: begin
          r_state <= CLR_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req  = r_busy;
  assign o_addr = r_addr;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/text_mem_arbiter.sv
// text_mem_arbiter
// Single-port character RAM scheduler. Display fetches (derived from the VGA
// counters) always win; the editor port and the clear engine share the
// remaining cycles round-robin.
//   i_clk, i_reset              : pixel clock, synchronous active-high reset
//   i_counter_x, i_counter_y    : pixel counters from the sync generator
//   i_ed_req/we/addr/wdata      : editor request, held until o_ed_ack
//   o_ed_ack                    : one-cycle grant pulse (t+1)
//   o_ed_rdata, o_ed_rvalid     : editor read return (t+3)
//   i_clr_start                 : start a clear-screen pass
//   o_clr_busy, o_clr_done      : clear status
//   o_mem_en/we/addr/wdata      : registered RAM strobes (t+1)
//   i_mem_rdata                 : RAM data, one cycle after o_mem_en
//   o_disp_char, o_disp_valid   : display fetch return (t+3)
import text_pkg::*;

module text_mem_arbiter (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [9:0]        i_counter_x,
  input  logic [9:0]        i_counter_y,
  input  logic              i_ed_req,
  input  logic              i_ed_we,
  input  logic [ADDR_W-1:0] i_ed_addr,
  input  logic [7:0]        i_ed_wdata,
  output logic              o_ed_ack,
  output logic [7:0]        o_ed_rdata,
  output logic              o_ed_rvalid,
  input  logic              i_clr_start,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_disp_char,
  output logic              o_disp_valid
);

  logic              w_slot;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_ed_ok;
  logic              w_ed_in_range;
  logic              w_clr_req;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_gnt_disp;
  logic              w_gnt_ed;
  logic              w_gnt_clr;

  logic              r_rr_clr;      // 1: clear has priority next, 0: editor
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_ed_ack;
  logic              r_p1_disp, r_p1_rd, r_p1_oob;
  logic              r_p2_disp, r_p2_rd, r_p2_oob;
  logic [7:0]        r_disp_char;
  logic              r_disp_valid;
  logic [7:0]        r_ed_rdata;
  logic              r_ed_rvalid;

  // One fetch per 8-pixel character cell, active area only.
  assign w_slot        = (i_counter_x < 10'd640) && (i_counter_y < 10'd480) &&
                         (i_counter_x[2:0] == 3'd0);
  assign w_disp_addr   = cell_addr(i_counter_y[8:3], i_counter_x[9:3]);
  // The editor holds req through the ack cycle, so that cycle is not a new request.
  assign w_ed_ok       = i_ed_req && !r_ed_ack;
  assign w_ed_in_range = (i_ed_addr < NUM_CELLS);

  text_clear_engine u_clear (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_clr_start),
    .i_grant (w_gnt_clr),
    .o_req   (w_clr_req),
    .o_addr  (w_clr_addr),
    .o_busy  (o_clr_busy),
    .o_done  (o_clr_done)
  );

  // Per-cycle grant: display slot first, then editor/clear round-robin.
  always_comb begin
    w_gnt_disp = 1'b0;
    w_gnt_ed   = 1'b0;
    w_gnt_clr  = 1'b0;
    if (w_slot) begin
      w_gnt_disp = 1'b1;
    end else if (w_ed_ok && w_clr_req) begin
      if (r_rr_clr) begin
        w_gnt_clr = 1'b1;
      end else begin
        w_gnt_ed = 1'b1;
      end
    end else if (w_ed_ok) begin
      w_gnt_ed = 1'b1;
    end else if (w_clr_req) begin
      w_gnt_clr = 1'b1;
    end else begin
      w_gnt_disp = 1'b0;
    end
  end

  // RAM command register, editor ack and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= 8'h00;
      r_ed_ack    <= 1'b0;
      r_rr_clr    <= 1'b0;
    end else begin
      // Out-of-range editor cells are acknowledged but never touch the RAM.
      r_mem_en <= w_gnt_disp | w_gnt_clr | (w_gnt_ed & w_ed_in_range);
      r_mem_we <= w_gnt_clr | (w_gnt_ed & i_ed_we & w_ed_in_range);
      r_ed_ack <= w_gnt_ed;
      if (w_gnt_disp) begin
        r_mem_addr <= w_disp_addr;
      end else if (w_gnt_clr) begin
        r_mem_addr  <= w_clr_addr;
        r_mem_wdata <= CLEAR_CHAR;
      end else if (w_gnt_ed && w_ed_in_range) begin
        r_mem_addr  <= i_ed_addr;
        r_mem_wdata <= i_ed_wdata;
      end
      if (w_gnt_ed) begin
        r_rr_clr <= 1'b1;
      end else if (w_gnt_clr) begin
        r_rr_clr <= 1'b0;
      end
    end
  end

  // Read-return pipeline: tags ride alongside the RAM latency, data lands at t+3.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_p1_disp    <= 1'b0;
      r_p1_rd      <= 1'b0;
      r_p1_oob     <= 1'b0;
      r_p2_disp    <= 1'b0;
      r_p2_rd      <= 1'b0;
      r_p2_oob     <= 1'b0;
      r_disp_char  <= 8'h00;
      r_disp_valid <= 1'b0;
      r_ed_rdata   <= 8'h00;
      r_ed_rvalid  <= 1'b0;
    end else begin
      r_p1_disp    <= w_gnt_disp;
      r_p1_rd      <= w_gnt_ed & ~i_ed_we;
      r_p1_oob     <= ~w_ed_in_range;
      r_p2_disp    <= r_p1_disp;
      r_p2_rd      <= r_p1_rd;
      r_p2_oob     <= r_p1_oob;
      r_disp_valid <= r_p2_disp;
      r_ed_rvalid  <= r_p2_rd;
      if (r_p2_disp) begin
        r_disp_char <= i_mem_rdata;
      end
      if (r_p2_rd) begin
        r_ed_rdata <= r_p2_oob ? 8'h00 : i_mem_rdata;
      end
    end
  end

  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_ed_ack     = r_ed_ack;
  assign o_ed_rdata   = r_ed_rdata;
  assign o_ed_rvalid  = r_ed_rvalid;
  assign o_disp_char  = r_disp_char;
  assign o_disp_valid = r_disp_valid;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// tb_text_mem_arbiter
// Directed bench for text_mem_arbiter with a behavioural single-port RAM.
module tb_text_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [9:0]  cx, cy;
  logic        ed_req, ed_we;
  logic [12:0] ed_addr;
  logic [7:0]  ed_wdata;
  logic        ed_ack;
  logic [7:0]  ed_rdata;
  logic        ed_rvalid;
  logic        clr_start, clr_busy, clr_done;
  logic        mem_en, mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  disp_char;
  logic        disp_valid;

  logic        do_preload;
  logic [7:0]  ram [0:8191];

  int n_checks = 0;
  int n_fail   = 0;

  text_mem_arbiter dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_counter_x  (cx),
    .i_counter_y  (cy),
    .i_ed_req     (ed_req),
    .i_ed_we      (ed_we),
    .i_ed_addr    (ed_addr),
    .i_ed_wdata   (ed_wdata),
    .o_ed_ack     (ed_ack),
    .o_ed_rdata   (ed_rdata),
    .o_ed_rvalid  (ed_rvalid),
    .i_clr_start  (clr_start),
    .o_clr_busy   (clr_busy),
    .o_clr_done   (clr_done),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_disp_char  (disp_char),
    .o_disp_valid (disp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Character RAM model: read-first, data one cycle after the strobe.
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 8192; i++) ram[i] <= i[7:0];
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Free-running counters from line y0 for nlines lines, checking every display return.
  task automatic run_video(input int y0, input int nlines);
    int d1v, d2v, d3v, d1c, d2c, d3c, lcnt, y;
    d1v = 0; d2v = 0; d3v = 0; d1c = 0; d2c = 0; d3c = 0;
    for (int l = 0; l < nlines; l++) begin
      y = y0 + l;
      lcnt = 0;
      for (int x = 0; x < 800; x++) begin
        check_eq("disp_valid", disp_valid, d3v);
        if (d3v != 0) check_eq("disp_char", disp_char, d3c);
        if (disp_valid) lcnt++;
        d3v = d2v; d3c = d2c; d2v = d1v; d2c = d1c;
        cx = 10'(x);
        cy = 10'(y);
        d1v = (x < 640 && y < 480 && (x % 8) == 0) ? 1 : 0;
        d1c = ((y / 8) * 80 + x / 8) % 256;
        tick();
      end
      check_eq("line_cnt", lcnt, (y < 480) ? 80 : 0);
    end
    cx = 10'd700;
    cy = 10'd500;
  endtask

  // One editor transaction in blanking: ack latency, RAM command, read return.
  task automatic ed_access(input string tag, input logic we, input logic [12:0] addr,
                           input logic [7:0] wd, input logic exp_en, input logic [7:0] exp_rd);
    int waited;
    ed_req = 1'b1; ed_we = we; ed_addr = addr; ed_wdata = wd;
    tick();
    waited = 1;
    while (!ed_ack && waited < 8) begin
      tick();
      waited++;
    end
    check_eq({tag, "_ack_lat"}, waited, 1);
    check_eq({tag, "_mem_en"}, mem_en, exp_en);
    if (exp_en) begin
      check_eq({tag, "_mem_addr"}, mem_addr, addr);
      check_eq({tag, "_mem_we"}, mem_we, we);
      if (we) check_eq({tag, "_mem_wdata"}, mem_wdata, wd);
    end
    ed_req = 1'b0;
    tick();
    check_eq({tag, "_rvalid_early"}, ed_rvalid, 0);
    tick();
    check_eq({tag, "_rvalid"}, ed_rvalid, !we);
    if (!we) check_eq({tag, "_rdata"}, ed_rdata, exp_rd);
    tick();
  endtask

  initial begin
    int prev_kind, kind, n_wr, alt_err, done_cnt, bad, found, fin, done_seen;
    logic [12:0] done_addr;

    reset = 1'b1; do_preload = 1'b1;
    cx = 10'd700; cy = 10'd500;
    ed_req = 1'b0; ed_we = 1'b0; ed_addr = 13'd0; ed_wdata = 8'h00;
    clr_start = 1'b0;
    tick(); tick();
    do_preload = 1'b0;
    reset = 1'b0;

    // Reset state
    check_eq("rst_ctl", {mem_en, mem_we, ed_ack, ed_rvalid, disp_valid, clr_busy, clr_done}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_data", {mem_wdata, ed_rdata, disp_char}, 0);
    tick();

    // Display fetches: two active lines, last active line and first blank line
    run_video(0, 2);
    run_video(479, 2);
    tick();

    // Display slot beats a waiting editor request
    cx = 10'd8; cy = 10'd16;
    ed_req = 1'b1; ed_we = 1'b0; ed_addr = 13'd7;
    tick();
    check_eq("dfirst_mem_en", mem_en, 1);
    check_eq("dfirst_mem_addr", mem_addr, 161);
    check_eq("dfirst_ack_early", ed_ack, 0);
    cx = 10'd9;
    tick();
    check_eq("dfirst_ack", ed_ack, 1);
    check_eq("dfirst_ed_addr", mem_addr, 7);
    ed_req = 1'b0; cx = 10'd700; cy = 10'd500;
    tick();
    check_eq("dfirst_disp_valid", disp_valid, 1);
    check_eq("dfirst_disp_char", disp_char, 8'hA1);
    tick();
    check_eq("dfirst_rvalid", ed_rvalid, 1);
    check_eq("dfirst_rdata", ed_rdata, 8'h07);
    tick();

    // Editor write/read in blanking, then an out-of-range read
    ed_access("wr4799", 1'b1, 13'd4799, 8'h41, 1'b1, 8'h00);
    ed_access("rd4799", 1'b0, 13'd4799, 8'h00, 1'b1, 8'h41);
    ed_access("oob5000", 1'b0, 13'd5000, 8'h00, 1'b0, 8'h00);

    // Clear with the editor requesting continuously: grants must alternate
    ed_we = 1'b0; ed_addr = 13'd100; ed_req = 1'b1; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    prev_kind = 0; n_wr = 0; alt_err = 0; done_cnt = 0; done_seen = 0; fin = 0;
    done_addr = 13'd0;
    for (int i = 0; i < 10000 && fin == 0; i++) begin
      kind = (mem_en && mem_we) ? 2 : (ed_ack ? 1 : 0);
      if ((mem_en && mem_we && ed_ack) || kind == 0 || kind == prev_kind) alt_err++;
      prev_kind = kind;
      if (mem_en && mem_we) begin
        n_wr++;
        if (mem_wdata != 8'h20) alt_err++;
      end
      if (clr_done) begin
        done_seen = 1; done_cnt = n_wr; done_addr = mem_addr;
      end
      if (done_seen != 0 && ed_ack) begin
        ed_req = 1'b0; fin = 1;
      end
      tick();
    end
    check_eq("clr_finished", fin, 1);
    check_eq("clr_alternate", alt_err, 0);
    check_eq("clr_writes_at_done", done_cnt, 4800);
    check_eq("clr_last_addr", done_addr, 4799);
    check_eq("clr_busy_after", clr_busy, 0);
    tick(); tick();
    bad = 0;
    for (int i = 0; i < 4800; i++) if (ram[i] !== 8'h20) bad++;
    check_eq("clr_cells", bad, 0);
    check_eq("clr_beyond", ram[4800], 8'hC0);
    ed_access("rd4800", 1'b0, 13'd4800, 8'h00, 1'b0, 8'h00);
    ed_access("rd0", 1'b0, 13'd0, 8'h00, 1'b1, 8'h20);

    // Reset drops an in-flight display fetch
    cx = 10'd8; cy = 10'd16;
    tick();
    reset = 1'b1; cx = 10'd700; cy = 10'd500;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_disp_drop", disp_valid, 0);
      tick();
    end

    // Reset during a clear, then restart from address 0
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      if (mem_en && mem_we && mem_addr == 13'd1234) found = 1;
      else tick();
    end
    check_eq("clr_reach_1234", found, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_clr_busy", clr_busy, 0);
    check_eq("rst_clr_mem_en", mem_en, 0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check_eq("restart_busy", clr_busy, 1);
    tick();
    check_eq("restart_first", {mem_en, mem_we, mem_addr}, {2'b11, 13'd0});
    n_wr = 1; done_seen = 0;
    for (int i = 0; i < 6000 && done_seen == 0; i++) begin
      tick();
      if (mem_en && mem_we) n_wr++;
      if (clr_done) done_seen = 1;
    end
    check_eq("restart_done", done_seen, 1);
    check_eq("restart_writes", n_wr, 4800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
